pixel_binarizer: RTL and testbench
==================================

# pixel_binarizer

Input stage of the recognition datapath: accepts a raster stream of grayscale pixels and thresholds each pixel to one bit. It packs each image row into a single word and hands complete rows downstream to the gate-level feature logic, which consumes 1-bit pixel signals. It absorbs one row of backpressure without stalling the pixel source mid-row.

## Interface
- PIX_W, 8, grayscale pixel width
- WORD_W, 28, pixels per row (packed row width)
- ROWS, 28, rows per frame
- ROW_IDX_W, 5, width of row index; must satisfy 2^ROW_IDX_W >= ROWS
- THRESH, 128, binarization threshold (used when runtime threshold is compiled out)

- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_pixel is valid
- in_ready  output  1  block accepts a pixel this cycle
- in_pixel  input  PIX_W  unsigned grayscale pixel, raster order
- out_valid  output  1  out_row holds a complete row
- out_ready  input  1  downstream accepts the row
- out_row  output  WORD_W  packed row; bit 0 = leftmost pixel
- out_row_idx  output  ROW_IDX_W  row number of out_row, 0..ROWS-1
- out_last  output  1  out_row is row ROWS-1
- frame_done  output  1  one-cycle pulse after the last row of a frame is handshaked

## Operation
- Pixel accept = in_valid && in_ready. Row accept = out_valid && out_ready.
- Bit = 1 when in_pixel >= threshold (unsigned compare), else 0. Pixel 0 equal to threshold gives 1.
- col counter 0..WORD_W-1. The accepted pixel's bit is written to pack register bit [col], then col increments. At WORD_W-1 col wraps to 0.
- row counter 0..ROWS-1. It increments when the last pixel of a row is accepted and wraps to 0 after ROWS-1.
- When the pixel at col = WORD_W-1 is accepted:
  - the full row (pack bits 0..WORD_W-2 plus the new bit) loads into the output register;
  - out_row_idx is set to the current row;
  - out_last is set to (row == ROWS-1);
  - out_valid is set to 1.
- The pack register is not cleared between rows. Every bit is overwritten before the row is used.
- in_ready = !(col == WORD_W-1 && out_valid && !out_ready).
  - Mid-row pixels are always accepted.
  - Only the row-completing pixel stalls, and only while the output register is occupied and not draining.
- Simultaneous row accept and row-completing pixel accept: the output register loads the new row and out_valid stays 1.
- Row accept with no new row loading clears out_valid.
- out_row, out_row_idx and out_last are stable while out_valid && !out_ready.
- frame_done pulses for exactly one cycle, the cycle after a row accept with out_last = 1.
- Reset (at any time, including mid-row or mid-frame):
  - col = 0, row = 0, pack register = 0;
  - out_valid = 0, out_row = 0, out_row_idx = 0, out_last = 0, frame_done = 0;
  - the partial row is discarded. in_ready is 1 after reset.

## Timing
- Latency: the row-completing pixel is accepted at edge N; out_valid = 1 and out_row are visible after edge N.
- Throughput: 1 pixel/cycle sustained when out_ready is held 1. There is no bubble at row boundaries.
- in_ready is combinational from out_ready, col and out_valid. There is no combinational path from in_valid or in_pixel to any output.
- frame_done is registered. It is asserted in the cycle after the final row handshake edge.

## Configuration
- BINARIZER_RUNTIME_THRESH_EN defined:
  - adds port thresh  input  PIX_W;
  - thresh is sampled on every pixel accept and used for that pixel's compare;
  - parameter THRESH is ignored.
- Undefined: no thresh port; the compare uses the constant THRESH.

## Test plan
- Feed 28 pixels alternating 200/50 with out_ready=1. Required: after the 28th accept, out_valid=1, out_row=28'h5555555 (bit0=1), out_row_idx=0, out_last=0. in_ready stays 1 throughout.
- Boundary compare with THRESH=128. Required: pixels 127 → 0, 128 → 1, 255 → 1, 0 → 0 at their bit positions.
- Hold out_ready=0 and stream 2 rows. Required:
  - in_ready drops to 0 only at col=27 of row 1;
  - row 0 stays stable;
  - raising out_ready accepts row 0 and the stalled pixel in the same cycle;
  - out_valid stays 1 with out_row_idx=1.
- Stream a full 28×28 frame, all pixels 255. Required: 28 rows of 28'hFFFFFFF with out_row_idx 0..27, out_last only on row 27, and one frame_done pulse the cycle after the row-27 handshake. row and col are then 0.
- Assert rst after 10 pixels of row 3. Required: all outputs 0 and in_ready=1 during reset. The next 28 pixels form row 0.
- With BINARIZER_RUNTIME_THRESH_EN: thresh=10 for the first 14 pixels and 250 for the rest, all pixels 100. Required: out_row=28'h0003FFF.

Source files
------------

// File: rtl/pixel_binarizer.sv
// pixel_binarizer: thresholds a raster stream of grayscale pixels to 1 bit,
// packs each row into one WORD_W-bit word and hands complete rows downstream
// through a single-entry output register with valid/ready handshake.
// Optional feature: define BINARIZER_RUNTIME_THRESH_EN to add a per-pixel
// runtime threshold port (thresh); otherwise the constant THRESH is used.
module pixel_binarizer #(
  parameter int PIX_W     = 8,
  parameter int WORD_W    = 28,
  parameter int ROWS      = 28,
  parameter int ROW_IDX_W = 5,
  parameter int THRESH    = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PIX_W-1:0]     in_pixel,
`ifdef BINARIZER_RUNTIME_THRESH_EN
  input  logic [PIX_W-1:0]     thresh,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_row,
  output logic [ROW_IDX_W-1:0] out_row_idx,
  output logic                 out_last,
  output logic                 frame_done
);

  localparam int COL_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  // Unsigned compare: a pixel equal to the threshold maps to 1.
  function automatic logic binarize(input logic [PIX_W-1:0] pix,
                                    input logic [PIX_W-1:0] thr);
    return (pix >= thr);
  endfunction

  logic [COL_W-1:0]     r_col_p0;
  logic [ROW_IDX_W-1:0] r_row_p0;
  logic [WORD_W-1:0]    r_pack_p0;
  logic                 r_vld_p1;
  logic [WORD_W-1:0]    r_row_p1;
  logic [ROW_IDX_W-1:0] r_idx_p1;
  logic                 r_last_p1;
  logic                 r_frame_done_p2;

  logic [PIX_W-1:0]  w_thresh;
  logic              w_bit;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_pix_acc;
  logic              w_row_acc;
  logic              w_row_done;
  logic              w_in_ready;
  logic [WORD_W-1:0] w_full_row;

`ifdef BINARIZER_RUNTIME_THRESH_EN
  assign w_thresh = thresh;
`else
  assign w_thresh = PIX_W'(THRESH);
`endif

  assign w_bit      = binarize(in_pixel, w_thresh);
  assign w_col_last = (r_col_p0 == COL_W'(WORD_W - 1));
  assign w_row_last = (r_row_p0 == ROW_IDX_W'(ROWS - 1));
  assign w_row_acc  = r_vld_p1 && out_ready;
  // Only the row-completing pixel can stall, and only while the output
  // register is full and not draining this cycle.
  assign w_in_ready = !(w_col_last && r_vld_p1 && !out_ready);
  assign w_pix_acc  = in_valid && w_in_ready;
  assign w_row_done = w_pix_acc && w_col_last;

  // Complete row = previously packed bits plus the bit arriving now.
  always_comb begin
    w_full_row             = r_pack_p0;
    w_full_row[WORD_W-1]   = w_bit;
  end

  // ---- stage p0: column/row position and the packing register ----
  // Column and row counters advance on every accepted pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_p0 <= '0;
      r_row_p0 <= '0;
    end else if (w_pix_acc) begin
      if (w_col_last) begin
        r_col_p0 <= '0;
        r_row_p0 <= w_row_last ? '0 : r_row_p0 + 1'b1;
      end else begin
        r_col_p0 <= r_col_p0 + 1'b1;
      end
    end
  end

  // Pack register is never cleared between rows; each bit is rewritten first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pack_p0 <= '0;
    end else if (w_pix_acc) begin
      r_pack_p0[r_col_p0] <= w_bit;
    end
  end

  // ---- stage p1: single-entry output row register ----
  // Loads on row completion (even while draining); clears on a bare drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_row_p1  <= '0;
      r_idx_p1  <= '0;
      r_last_p1 <= 1'b0;
    end else if (w_row_done) begin
      r_vld_p1  <= 1'b1;
      r_row_p1  <= w_full_row;
      r_idx_p1  <= r_row_p0;
      r_last_p1 <= w_row_last;
    end else if (w_row_acc) begin
      r_vld_p1  <= 1'b0;
    end
  end

  // ---- stage p2: end-of-frame pulse ----
  // One-cycle pulse after the handshake of the frame's last row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_done_p2 <= 1'b0;
    end else begin
      r_frame_done_p2 <= w_row_acc && r_last_p1;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_vld_p1;
  assign out_row     = r_row_p1;
  assign out_row_idx = r_idx_p1;
  assign out_last    = r_last_p1;
  assign frame_done  = r_frame_done_p2;

endmodule

// File: tb/tb_pixel_binarizer.sv
// Self-checking bench for pixel_binarizer: directed scenarios plus random
// traffic, all compared against a row-level behavioural model.
module tb_pixel_binarizer;
  localparam int PIX_W     = 8;
  localparam int WORD_W    = 28;
  localparam int ROWS      = 28;
  localparam int ROW_IDX_W = 5;
  localparam int THRESH    = 128;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [PIX_W-1:0]     in_pixel;
  logic [PIX_W-1:0]     thresh;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_W-1:0]    out_row;
  logic [ROW_IDX_W-1:0] out_row_idx;
  logic                 out_last;
  logic                 frame_done;

  always #5 clk = ~clk;

  pixel_binarizer #(
    .PIX_W(PIX_W), .WORD_W(WORD_W), .ROWS(ROWS),
    .ROW_IDX_W(ROW_IDX_W), .THRESH(THRESH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
`ifdef BINARIZER_RUNTIME_THRESH_EN
    .thresh(thresh),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last), .frame_done(frame_done)
  );

  int n_chk = 0;
  int n_err = 0;
  int fd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: accepted bits of the row in progress, plus the row
  // currently held for downstream.
  bit              m_bits[$];
  int              m_row;
  bit              m_ov;
  logic [WORD_W-1:0] m_orow;
  int              m_oidx;
  bit              m_olast;
  bit              m_fd;
  logic [PIX_W-1:0] m_thr;

  function automatic logic [WORD_W-1:0] pack_row();
    logic [WORD_W-1:0] r;
    r = '0;
    foreach (m_bits[i]) r[i] = m_bits[i];
    return r;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_row = 0; m_ov = 0; m_orow = '0; m_oidx = 0; m_olast = 0; m_fd = 0;
  endtask

  // One clock cycle: drive, check mid-cycle, then advance the model.
  task automatic step(input bit v, input logic [PIX_W-1:0] p, input bit ordy);
    bit exp_rdy, pacc, racc;
    in_valid = v; in_pixel = p; out_ready = ordy; thresh = m_thr;
    #2;
    exp_rdy = !(m_bits.size() == WORD_W - 1 && m_ov && !ordy);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_row", out_row, m_orow);
      chk("out_row_idx", out_row_idx, m_oidx);
      chk("out_last", out_last, m_olast);
    end
    chk("frame_done", frame_done, m_fd);
    if (frame_done === 1'b1) fd_cnt++;
    pacc = v && (in_ready === 1'b1);
    racc = m_ov && ordy;
    @(posedge clk); #1;
    m_fd = racc && m_olast;
    if (racc) m_ov = 0;
    if (pacc) begin
      m_bits.push_back(p >= m_thr);
      if (m_bits.size() == WORD_W) begin
        m_orow  = pack_row();
        m_oidx  = m_row;
        m_olast = (m_row == ROWS - 1);
        m_ov    = 1;
        m_bits.delete();
        m_row   = (m_row + 1) % ROWS;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_row_idx", out_row_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  logic [PIX_W-1:0] bpat [4];

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0;
    m_thr = PIX_W'(THRESH); thresh = m_thr;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Alternating bright/dark row.
    for (int i = 0; i < WORD_W; i++) step(1, (i % 2 == 0) ? 8'd200 : 8'd50, 1);
    chk("alt_row", out_row, 28'h5555555);
    chk("alt_idx", out_row_idx, 0);
    chk("alt_last", out_last, 0);
    chk("alt_valid", out_valid, 1);

    // Threshold boundary values 127,128,255,0 repeated.
    bpat[0] = 8'd127; bpat[1] = 8'd128; bpat[2] = 8'd255; bpat[3] = 8'd0;
    for (int i = 0; i < WORD_W; i++) step(1, bpat[i % 4], 1);
    chk("bnd_row", out_row, 28'h6666666);
    chk("bnd_idx", out_row_idx, 1);

    // Backpressure: two rows with out_ready low, then release.
    do_reset();
    for (int i = 0; i < 2 * WORD_W - 1; i++) step(1, 8'($urandom), 0);
    chk("stall_rdy", in_ready, 0);
    chk("stall_idx", out_row_idx, 0);
    step(1, 8'd255, 0);
    step(1, 8'd255, 0);
    step(1, 8'd255, 1);
    chk("release_valid", out_valid, 1);
    chk("release_idx", out_row_idx, 1);
    chk("release_rdy", in_ready, 1);

    // Full frame of white pixels.
    do_reset();
    fd_cnt = 0;
    for (int i = 0; i < WORD_W * ROWS; i++) step(1, 8'd255, 1);
    chk("frame_last_row", out_row, 28'hFFFFFFF);
    chk("frame_last_idx", out_row_idx, ROWS - 1);
    chk("frame_last_flag", out_last, 1);
    for (int i = 0; i < 3; i++) step(0, 8'd0, 1);
    chk("frame_done_cnt", fd_cnt, 1);
    for (int i = 0; i < WORD_W; i++) step(1, 8'd0, 1);
    chk("next_frame_idx", out_row_idx, 0);

    // Reset in the middle of row 3.
    for (int i = 0; i < 2 * WORD_W + 10; i++) step(1, 8'($urandom), 1);
    do_reset();
    for (int i = 0; i < WORD_W; i++) step(1, 8'd200, 1);
    chk("post_rst_idx", out_row_idx, 0);
    chk("post_rst_row", out_row, 28'hFFFFFFF);

`ifdef BINARIZER_RUNTIME_THRESH_EN
    // Runtime threshold changes mid-row.
    do_reset();
    for (int i = 0; i < WORD_W; i++) begin
      m_thr = (i < 14) ? 8'd10 : 8'd250;
      step(1, 8'd100, 1);
    end
    chk("rt_thresh_row", out_row, 28'h0003FFF);
`endif

    // Random traffic with random backpressure.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [PIX_W-1:0] p;
`ifdef BINARIZER_RUNTIME_THRESH_EN
      m_thr = 8'($urandom);
`endif
      p = ($urandom_range(0, 3) == 0) ? 8'(m_thr + 8'($urandom_range(0, 2)) - 8'd1)
                                      : 8'($urandom);
      step($urandom_range(0, 9) < 8, p, $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 4; i++) step(0, 8'd0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
